// File: rtl/chaser_monitor.sv
// Receive-side checker for a rotating one-hot LED bus: locks onto the rotation,
// decodes the lit position, flags step/timing/one-hot violations and counts laps.
module chaser_monitor #(
    parameter int WIDTH        = 8,
    parameter int ROTATE_SPEED = 4,
    parameter int LAP_W        = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [WIDTH-1:0]         i_led_pattern,
    input  logic                     i_enable,
    input  logic                     i_clear,
    output logic                     o_locked,
    output logic [$clog2(WIDTH)-1:0] o_position,
    output logic                     o_onehot,
    output logic                     o_err_onehot,
    output logic                     o_err_step,
    output logic                     o_err_timing,
    output logic [LAP_W-1:0]         o_lap_count
);
    localparam int POS_W = $clog2(WIDTH);
    localparam int DW    = $clog2(ROTATE_SPEED + 2);
    localparam logic [DW-1:0] RS_D   = DW'(ROTATE_SPEED);
    localparam logic [DW-1:0] RS_MAX = DW'(ROTATE_SPEED + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACQUIRE, S_TRACK, S_FAULT} state_t;

    state_t             r_state, w_state_next;
    logic [WIDTH-1:0]   r_prev;
    logic [DW-1:0]      r_dwell, w_dwell_next;
    logic [POS_W-1:0]   r_pos, w_pos;
    logic               r_onehot;
    logic               r_err_onehot, r_err_step, r_err_timing;
    logic [LAP_W-1:0]   r_lap;

    logic               w_onehot, w_change, w_legal;
    logic [WIDTH-1:0]   w_rotl;
    logic               w_set_oh, w_set_step, w_set_tim, w_lap_inc;

    assign w_onehot = $onehot(i_led_pattern);
    assign w_change = (i_led_pattern != r_prev);
    assign w_rotl   = {r_prev[WIDTH-2:0], r_prev[WIDTH-1]};
    assign w_legal  = w_change && (i_led_pattern == w_rotl);

    always_comb begin
        w_pos = '0;
        for (int i = 0; i < WIDTH; i++)
            if (i_led_pattern[i]) w_pos = POS_W'(i);
    end

    // Enabled edges since the last change; the change edge itself counts when enabled.
    always_comb begin
        w_dwell_next = r_dwell;
        if (w_change)
            w_dwell_next = DW'(i_enable);
        else if (i_enable && r_dwell != RS_MAX)
            w_dwell_next = r_dwell + DW'(1);
    end

    always_comb begin
        w_state_next = r_state;
        w_set_oh     = 1'b0;
        w_set_step   = 1'b0;
        w_set_tim    = 1'b0;
        w_lap_inc    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_onehot) w_state_next = S_ACQUIRE;
            end
            S_ACQUIRE: begin
                if (!w_onehot || (w_change && !w_legal))
                    w_state_next = S_IDLE;
                else if (w_legal)
                    w_state_next = S_TRACK;
            end
            S_TRACK: begin
                if (!w_onehot) begin
                    w_set_oh = 1'b1;
                end else begin
                    w_set_step = w_change && !w_legal;
                    // Any step off the exact dwell is mistimed; a missing step is overdue.
                    w_set_tim  = (w_change && r_dwell != RS_D) ||
                                 (!w_change && i_enable && r_dwell == RS_D);
                end
                if (w_set_oh || w_set_step || w_set_tim)
                    w_state_next = S_FAULT;
                else if (w_legal && r_prev[WIDTH-1])
                    w_lap_inc = 1'b1;
            end
            S_FAULT: w_state_next = S_FAULT;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_prev       <= '0;
            r_dwell      <= '0;
            r_pos        <= '0;
            r_onehot     <= 1'b0;
            r_err_onehot <= 1'b0;
            r_err_step   <= 1'b0;
            r_err_timing <= 1'b0;
            r_lap        <= '0;
        end else begin
            r_prev   <= i_led_pattern;
            r_onehot <= w_onehot;
            if (w_onehot) r_pos <= w_pos;
            if (i_clear) begin
                r_state      <= S_IDLE;
                r_dwell      <= '0;
                r_err_onehot <= 1'b0;
                r_err_step   <= 1'b0;
                r_err_timing <= 1'b0;
                r_lap        <= '0;
            end else begin
                r_state      <= w_state_next;
                r_dwell      <= w_dwell_next;
                r_err_onehot <= r_err_onehot | w_set_oh;
                r_err_step   <= r_err_step   | w_set_step;
                r_err_timing <= r_err_timing | w_set_tim;
                if (w_lap_inc) r_lap <= r_lap + LAP_W'(1);
            end
        end
    end

    assign o_locked     = (r_state == S_TRACK);
    assign o_position   = r_pos;
    assign o_onehot     = r_onehot;
    assign o_err_onehot = r_err_onehot;
    assign o_err_step   = r_err_step;
    assign o_err_timing = r_err_timing;
    assign o_lap_count  = r_lap;
endmodule

// File: tb/tb_chaser_monitor.sv
// Bench for chaser_monitor: directed table, hand sequences for the corner cases,
// and randomized chaser traffic checked against a behavioural reference model.
module tb_chaser_monitor;
    localparam int RS = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, clear = 1'b0, en = 1'b0;
    logic [7:0] pat = 8'h00;

    logic       a_lk, a_oh, a_eo, a_es, a_et;
    logic [2:0] a_pos;
    logic [15:0] a_lap;
    logic       b_lk, b_oh, b_eo, b_es, b_et;
    logic [2:0] b_pos;
    logic [1:0] b_lap;

    chaser_monitor #(.WIDTH(8), .ROTATE_SPEED(RS), .LAP_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_led_pattern(pat), .i_enable(en), .i_clear(clear),
        .o_locked(a_lk), .o_position(a_pos), .o_onehot(a_oh), .o_err_onehot(a_eo),
        .o_err_step(a_es), .o_err_timing(a_et), .o_lap_count(a_lap));

    chaser_monitor #(.WIDTH(8), .ROTATE_SPEED(RS), .LAP_W(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_led_pattern(pat), .i_enable(en), .i_clear(clear),
        .o_locked(b_lk), .o_position(b_pos), .o_onehot(b_oh), .o_err_onehot(b_eo),
        .o_err_step(b_es), .o_err_timing(b_et), .o_lap_count(b_lap));

    int n_vec = 0, n_bad = 0;

    // ---------------- reference model ----------------
    localparam int M_IDLE = 0, M_ACQ = 1, M_TRACK = 2, M_FAULT = 3;
    logic [7:0] m_prev = 8'h00;
    int  m_dwell = 0, m_mode = M_IDLE, m_pos = 0, m_lap = 0;
    bit  m_oh = 0, m_e1 = 0, m_e2 = 0, m_e3 = 0;

    function automatic logic [7:0] rotl8(input logic [7:0] p);
        return 8'(((int'(p) * 2) | (int'(p) / 128)) & 255);
    endfunction

    function automatic int idx_of(input logic [7:0] p);
        for (int i = 0; i < 8; i++) if (p[i]) return i;
        return 0;
    endfunction

    task automatic model_step(input logic [7:0] p, input logic e, input logic c, input logic r);
        bit oh, chg, legal, bad;
        int nd;
        if (r) begin
            m_prev = 0; m_dwell = 0; m_mode = M_IDLE; m_pos = 0; m_oh = 0;
            m_e1 = 0; m_e2 = 0; m_e3 = 0; m_lap = 0;
            return;
        end
        oh    = ($countones(p) == 1);
        chg   = (p != m_prev);
        legal = chg && (p == rotl8(m_prev));
        if (chg) nd = int'(e);
        else     nd = (m_dwell + int'(e) > RS + 1) ? RS + 1 : m_dwell + int'(e);
        m_oh = oh;
        if (oh) m_pos = idx_of(p);
        if (c) begin
            m_mode = M_IDLE; m_e1 = 0; m_e2 = 0; m_e3 = 0; m_lap = 0; nd = 0;
        end else if (m_mode == M_IDLE) begin
            if (oh) m_mode = M_ACQ;
        end else if (m_mode == M_ACQ) begin
            if (!oh || (chg && !legal)) m_mode = M_IDLE;
            else if (legal)             m_mode = M_TRACK;
        end else if (m_mode == M_TRACK) begin
            if (!oh) begin
                m_e1 = 1; m_mode = M_FAULT;
            end else begin
                bad = 0;
                if (chg && !legal)                  begin m_e2 = 1; bad = 1; end
                if (chg && m_dwell != RS)           begin m_e3 = 1; bad = 1; end
                if (!chg && e && m_dwell == RS)     begin m_e3 = 1; bad = 1; end
                if (bad) m_mode = M_FAULT;
                else if (legal && m_prev == 8'h80) m_lap++;
            end
        end
        m_dwell = nd;
        m_prev  = p;
    endtask

    // ---------------- drivers / checkers ----------------
    task automatic cyc(input logic [7:0] p, input logic e, input logic c, input logic r);
        pat = p; en = e; clear = c; rst = r;
        @(posedge clk);
        model_step(p, e, c, r);
        #1;
        n_vec++;
        if (a_lk !== (m_mode == M_TRACK) || a_pos !== 3'(m_pos) || a_oh !== m_oh ||
            a_eo !== m_e1 || a_es !== m_e2 || a_et !== m_e3 || a_lap !== 16'(m_lap) ||
            b_lap !== 2'(m_lap) || b_lk !== a_lk) begin
            n_bad++;
            $display("FAIL model t=%0t got lk=%0b pos=%0d oh=%0b err=%b%b%b lap=%0d/%0d want lk=%0b pos=%0d oh=%0b err=%b%b%b lap=%0d",
                     $time, a_lk, a_pos, a_oh, a_eo, a_es, a_et, a_lap, b_lap,
                     m_mode == M_TRACK, m_pos, m_oh, m_e1, m_e2, m_e3, m_lap);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    logic [7:0] ch_pat = 8'h01;
    int ch_cnt = 0;

    task automatic chase(input logic e, input logic c);
        cyc(ch_pat, e, c, 1'b0);
        if (e) begin
            ch_cnt++;
            if (ch_cnt == RS) begin ch_pat = rotl8(ch_pat); ch_cnt = 0; end
        end
    endtask

    // Run the chaser until the next cycle would first show pattern t.
    task automatic chase_to(input logic [7:0] t);
        int n = 0;
        while (!(ch_pat == t && ch_cnt == 0) && n < 200) begin chase(1'b1, 1'b0); n++; end
        chk("chase_to_bound", int'(n < 200), 1);
    endtask

    // ---------------- directed table ----------------
    typedef struct packed {
        logic [7:0] pat; logic en; logic clr;
        logic lk; logic [2:0] pos; logic oh; logic [2:0] err;
    } vec_t;
    vec_t tbl [22];

    initial begin
        int lap_exp [5];
        tbl[0]  = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'b000};
        tbl[1]  = '{8'hFF, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'b000};
        tbl[2]  = '{8'h01, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 3'b000};
        tbl[3]  = '{8'h01, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 3'b000};
        tbl[4]  = '{8'h01, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 3'b000};
        tbl[5]  = '{8'h01, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 3'b000};
        tbl[6]  = '{8'h02, 1'b1, 1'b0, 1'b1, 3'd1, 1'b1, 3'b000};
        tbl[7]  = '{8'h02, 1'b1, 1'b0, 1'b1, 3'd1, 1'b1, 3'b000};
        tbl[8]  = '{8'h02, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 3'b000};
        tbl[9]  = '{8'h02, 1'b1, 1'b0, 1'b1, 3'd1, 1'b1, 3'b000};
        tbl[10] = '{8'h02, 1'b1, 1'b0, 1'b1, 3'd1, 1'b1, 3'b000};
        tbl[11] = '{8'h04, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 3'b000};
        tbl[12] = '{8'h04, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 3'b000};
        tbl[13] = '{8'h04, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 3'b000};
        tbl[14] = '{8'h04, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 3'b000};
        tbl[15] = '{8'h18, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 3'b100};
        tbl[16] = '{8'h08, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 3'b100};
        tbl[17] = '{8'h08, 1'b1, 1'b1, 1'b0, 3'd3, 1'b1, 3'b000};
        tbl[18] = '{8'h08, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 3'b000};
        tbl[19] = '{8'h10, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 3'b000};
        tbl[20] = '{8'h20, 1'b1, 1'b0, 1'b0, 3'd5, 1'b1, 3'b001};
        tbl[21] = '{8'h20, 1'b1, 1'b1, 1'b0, 3'd5, 1'b1, 3'b000};
        lap_exp = '{1, 2, 3, 0, 1};

        // Reset state
        cyc(8'h00, 1'b0, 1'b0, 1'b1);
        cyc(8'h5A, 1'b1, 1'b0, 1'b1);
        chk("rst_locked", int'(a_lk), 0);
        chk("rst_pos", int'(a_pos), 0);
        chk("rst_onehot", int'(a_oh), 0);
        chk("rst_flags", int'({a_eo, a_es, a_et}), 0);
        chk("rst_lap", int'(a_lap), 0);

        for (int i = 0; i < 22; i++) begin
            cyc(tbl[i].pat, tbl[i].en, tbl[i].clr, 1'b0);
            n_vec++;
            if ({a_lk, a_pos, a_oh, a_eo, a_es, a_et} !==
                {tbl[i].lk, tbl[i].pos, tbl[i].oh, tbl[i].err}) begin
                n_bad++;
                $display("FAIL table[%0d] got lk=%0b pos=%0d oh=%0b err=%b%b%b want lk=%0b pos=%0d oh=%0b err=%b",
                         i, a_lk, a_pos, a_oh, a_eo, a_es, a_et,
                         tbl[i].lk, tbl[i].pos, tbl[i].oh, tbl[i].err);
            end
        end

        // 20 steps at full enable from 0x01
        cyc(8'h00, 1'b0, 1'b0, 1'b1);
        ch_pat = 8'h01; ch_cnt = 0;
        for (int c = 0; c <= 80; c++) begin
            chase(1'b1, 1'b0);
            if (c == 3) chk("lock_before_step", int'(a_lk), 0);
            if (c == 4) chk("lock_after_step", int'(a_lk), 1);
        end
        chk("run20_lap", int'(a_lap), 2);
        chk("run20_flags", int'({a_eo, a_es, a_et}), 0);
        chk("run20_pos", int'(a_pos), 4);

        // Enable toggled 1,0,0,1 during dwells
        for (int k = 0; k < 12; k++) chase(k % 4 == 0 || k % 4 == 3, 1'b0);
        for (int k = 0; k < 8; k++) chase(1'b1, 1'b0);
        chk("toggle_locked", int'(a_lk), 1);
        chk("toggle_flags", int'({a_eo, a_es, a_et}), 0);

        // 0x04 -> 0x10 at the correct time
        chase_to(8'h08);
        cyc(8'h10, 1'b1, 1'b0, 1'b0);
        chk("skip_err_step", int'(a_es), 1);
        chk("skip_locked", int'(a_lk), 0);
        chk("skip_other_flags", int'({a_eo, a_et}), 0);
        cyc(8'h10, 1'b1, 1'b1, 1'b0);
        chk("clear_flags", int'({a_eo, a_es, a_et}), 0);
        ch_pat = 8'h10; ch_cnt = 2;
        begin
            int n = 0;
            while (!a_lk && n < 40) begin chase(1'b1, 1'b0); n++; end
            chk("relock", int'(a_lk), 1);
        end

        // 0x08 held for 5 enabled edges
        chase_to(8'h08);
        for (int k = 1; k <= 4; k++) cyc(8'h08, 1'b1, 1'b0, 1'b0);
        chk("hold4_no_err", int'(a_et), 0);
        cyc(8'h08, 1'b1, 1'b0, 1'b0);
        chk("hold5_err_timing", int'(a_et), 1);
        chk("hold5_locked", int'(a_lk), 0);

        // Early step after 3 enabled edges
        cyc(8'h00, 1'b0, 1'b0, 1'b1);
        ch_pat = 8'h01; ch_cnt = 0;
        chase_to(8'h08);
        chk("early_pre_locked", int'(a_lk), 1);
        for (int k = 0; k < 3; k++) cyc(8'h08, 1'b1, 1'b0, 1'b0);
        chk("early_pre_err", int'(a_et), 0);
        cyc(8'h10, 1'b1, 1'b0, 1'b0);
        chk("early_err_timing", int'(a_et), 1);
        chk("early_err_step", int'(a_es), 0);

        // Lap wrap on the 2-bit counter
        cyc(8'h00, 1'b0, 1'b0, 1'b1);
        ch_pat = 8'h01; ch_cnt = 0;
        chase(1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 32; c++) chase(1'b1, 1'b0);
            chk($sformatf("lap2_%0d", k + 1), int'(b_lap), lap_exp[k]);
            chk($sformatf("lap16_%0d", k + 1), int'(a_lap), k + 1);
        end

        // rst together with clear mid-TRACK
        for (int c = 0; c < 5; c++) chase(1'b1, 1'b0);
        chk("pre_rst_locked", int'(a_lk), 1);
        cyc(ch_pat, 1'b1, 1'b1, 1'b1);
        chk("rstclr_outputs", int'({a_lk, a_pos, a_oh, a_eo, a_es, a_et}), 0);
        chk("rstclr_lap", int'(a_lap), 0);
        cyc(ch_pat, 1'b0, 1'b0, 1'b0);
        chk("rstclr_idle", int'(a_lk), 0);

        // Randomized traffic against the model
        ch_pat = 8'h01; ch_cnt = 0;
        for (int it = 0; it < 3000; it++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r < 5)
                cyc(ch_pat, 1'b1, 1'b0, 1'b1);
            else if (r < 25)
                chase($urandom_range(0, 1) == 1, 1'b1);
            else if (r < 40)
                cyc(8'($urandom_range(0, 255)), $urandom_range(0, 1) == 1, 1'b0, 1'b0);
            else if (r < 50) begin
                ch_cnt = $urandom_range(0, RS - 1);
                chase(1'b1, 1'b0);
            end else
                chase($urandom_range(0, 3) != 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/chaser_monitor.md
Name: chaser_monitor

Overview:
- Receive-side checker for the rotating one-hot LED bus driven by the light-chaser block.
- Observes the LED pattern and the shared enable, locks onto the rotation, and decodes the lit position.
- Checks that every step is a one-position circular left shift, taken at exactly ROTATE_SPEED enabled cycles.
- Raises sticky error flags and counts completed laps; used in self-checking benches and as an on-chip health monitor.

Parameters:
- WIDTH, 8: width of the LED bus.
- ROTATE_SPEED, 4: required number of enabled cycles per step. Legal range ≥1.
- LAP_W, 16: width of the lap counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- led_pattern  in  WIDTH  observed LED bus, same clock domain.
- enable  in  1  same enable that drives the chaser.
- clear  in  1  synchronous pulse; clears error flags and lap count, returns to IDLE.
- locked  out  1  high in TRACK only.
- position  out  clog2(WIDTH)  index of the lit bit; holds its last value when the pattern is not one-hot.
- onehot  out  1  registered; high when the current pattern has exactly one bit set.
- err_onehot  out  1  sticky: pattern not one-hot while in TRACK.
- err_step  out  1  sticky: changed pattern is not the rotate-left of the previous pattern.
- err_timing  out  1  sticky: a step came early or late.
- lap_count  out  LAP_W  completed laps (bit WIDTH-1 to bit 0 steps taken in TRACK); wraps modulo 2^LAP_W.

Behaviour:
- Reset: state=IDLE. All outputs are 0: locked, position, onehot, all err_* flags and lap_count. prev=0, dwell=0.
- Every edge: prev <= led_pattern. A "change" is led_pattern != prev. Outputs are registered, so there is 1-cycle latency from led_pattern.
- dwell counts edges with enable=1 since the last change.
  - On a change edge: dwell <= enable?1:0.
  - Otherwise: dwell <= dwell+enable, saturating at ROTATE_SPEED+1.
  - Exact ROTATE_SPEED spacing is therefore legal when the chaser and the monitor share enable.
- IDLE: on a one-hot pattern, go to ACQUIRE. Otherwise stay in IDLE. No errors are raised.
- ACQUIRE:
  - Change to the rotate-left of prev: go to TRACK and reset dwell. Timing is not checked on this step, because phase is unknown.
  - Non-one-hot pattern, or a change that is not a rotate-left: go back to IDLE with no error.
- TRACK, per edge:
  - Not one-hot: set err_onehot and go to FAULT. Step and timing are not evaluated.
  - Change, but not a rotate-left: set err_step and go to FAULT.
  - Legal change with dwell != ROTATE_SPEED: set err_timing and go to FAULT.
  - Legal change where the previous lit bit was bit WIDTH-1: lap_count+1.
  - No change, enable=1, and dwell already = ROTATE_SPEED (step overdue): set err_timing and go to FAULT.
  - A change while enable is low and dwell < ROTATE_SPEED counts as early: err_timing.
  - With enable=0 and no change, dwell is frozen and no error is possible.
- FAULT: locked=0. Flags hold. Stays in FAULT until clear or rst.
- clear: go to IDLE. Flags and lap_count go to 0 and dwell goes to 0. position and onehot continue tracking.
- Priority: rst > clear > error detection > lap increment.
- Several error conditions on the same edge set every applicable flag; err_onehot suppresses the other two.
- lap_count wraps from 2^LAP_W-1 to 0 silently.
- ROTATE_SPEED=1: a step is required on every enabled edge.

Test Plan:
- Chaser driven with ROTATE_SPEED=4, enable held high, 20 steps from 0x01:
  - locked rises one cycle after the first observed step.
  - No err_* flags.
  - lap_count=2 after pattern returns to 0x01 twice.
  - position tracks 0..7.
- enable toggled 1,0,0,1 during a dwell:
  - Step spacing is stretched in wall-clock cycles but equals 4 enabled cycles.
  - Remains locked, no errors.
- In TRACK, force led_pattern 0x04→0x10 at the correct time:
  - err_step=1, locked=0 next cycle.
  - Pulse clear: flags=0, state=IDLE, re-locks on the next legal step.
- In TRACK, 0x08 held for 5 enabled cycles:
  - err_timing=1 on the 5th enabled edge.
  - A separate run stepping after 3 enabled cycles also gives err_timing=1.
- In TRACK, drive 0x18:
  - err_onehot=1, err_step=0, err_timing=0.
  - In IDLE, 0x00 and 0xFF raise no flags.
- LAP_W=2, run 5 laps:
  - lap_count sequence 1,2,3,0,1.
- Assert rst mid-TRACK with clear=1 simultaneously:
  - All outputs 0 next cycle, state IDLE.
